// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor
// Passive observer of the CPU status outputs (pc, stall, flush). Keeps
// saturating performance counters for cycles, stalls, flushes, fetches and
// dropped trace entries. Every fetch is pushed into a PC trace FIFO that a
// host drains through a valid/ready port.
//
// Optional feature macro: TRACE_MONITOR_SQUASH_FILTER_EN
//   defined   : fetches sampled in a flush cycle are not pushed and
//               trace_squash_o is tied to 0.
//   undefined : every fetch is pushed with its flush bit as the squash flag.
//
// Handshake: trace_valid_o is high whenever the FIFO holds an entry; the head
// entry is transferred at a rising edge where trace_valid_o && trace_ready_i.
// trace_valid_o never depends on trace_ready_i, and the head only changes at
// a transfer edge or on clear/reset.

module cpu_trace_monitor #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              pc_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [31:0]              trace_pc_o,
  output logic                     trace_squash_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic [CNT_W-1:0]         cycle_cnt_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         flush_cnt_o,
  output logic [CNT_W-1:0]         fetch_cnt_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  // Event decode
  logic ev_cycle;
  logic ev_stall;
  logic ev_flush;
  logic ev_fetch;

  // FIFO control
  logic             push;
  logic             pop;
  logic             full;
  logic             accept;
  logic             drop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;

  // Trace storage: {pc, squash}
  logic [32:0] mem [DEPTH];
  logic [32:0] head_entry;

  // Counter registers
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] drop_cnt;

  // Saturating increment: holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic              ev);
    logic [CNT_W-1:0] r;
    r = v;
    if (ev && (v != {CNT_W{1'b1}})) begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // Classify the sampled CPU status into events; enable gates all of them
  always_comb begin
    ev_cycle = enable_i;
    ev_stall = enable_i & stall_i;
    ev_flush = enable_i & flush_i;
    // Stall wins over flush: a stalled cycle never fetches
    ev_fetch = enable_i & ~stall_i;
  end

  // FIFO push/pop decisions
  always_comb begin
`ifdef TRACE_MONITOR_SQUASH_FILTER_EN
    push = ev_fetch & ~flush_i;
`else
    push = ev_fetch;
`endif
    full   = (level == FULL_LEVEL);
    pop    = trace_valid_o & trace_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    accept = push & (~full | pop);
    drop   = push & full & ~pop;
  end

  // Pointer and occupancy tracking; clear overrides any event or pop
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (accept && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !accept) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // Trace storage write; contents are only observable through level, so no reset
  always_ff @(posedge clk_i) begin
    if (!clear_i && accept) begin
      mem[wr_ptr] <= {pc_i, flush_i};
    end
  end

  // Performance counters; clear zeroes them and discards this cycle's events
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      fetch_cnt <= '0;
      drop_cnt  <= '0;
    end else if (clear_i) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      fetch_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      cycle_cnt <= sat_inc(cycle_cnt, ev_cycle);
      stall_cnt <= sat_inc(stall_cnt, ev_stall);
      flush_cnt <= sat_inc(flush_cnt, ev_flush);
      fetch_cnt <= sat_inc(fetch_cnt, ev_fetch);
      drop_cnt  <= sat_inc(drop_cnt, drop);
    end
  end

  // Head read mux; outputs read zero while the FIFO is empty
  always_comb begin
    trace_valid_o = (level != '0);
    head_entry    = trace_valid_o ? mem[rd_ptr] : 33'd0;
    trace_pc_o    = head_entry[32:1];
`ifdef TRACE_MONITOR_SQUASH_FILTER_EN
    trace_squash_o = 1'b0;
`else
    trace_squash_o = head_entry[0];
`endif
  end

  // Counter and level outputs straight from registers
  always_comb begin
    fifo_level_o = level;
    cycle_cnt_o  = cycle_cnt;
    stall_cnt_o  = stall_cnt;
    flush_cnt_o  = flush_cnt;
    fetch_cnt_o  = fetch_cnt;
    drop_cnt_o   = drop_cnt;
  end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Testbench for cpu_trace_monitor: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based reference model. Counters are built 8 bits wide so the random
// phase reaches saturation.

module tb_cpu_trace_monitor;

  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]            pc;
  logic                   stall;
  logic                   flush;
  logic                   enable;
  logic                   clear;
  logic                   trace_ready;
  logic                   trace_valid;
  logic [31:0]            trace_pc;
  logic                   trace_squash;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CNT_W-1:0]       cycle_cnt, stall_cnt, flush_cnt, fetch_cnt, drop_cnt;

  cpu_trace_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .pc_i           (pc),
    .stall_i        (stall),
    .flush_i        (flush),
    .enable_i       (enable),
    .clear_i        (clear),
    .trace_valid_o  (trace_valid),
    .trace_ready_i  (trace_ready),
    .trace_pc_o     (trace_pc),
    .trace_squash_o (trace_squash),
    .fifo_level_o   (fifo_level),
    .cycle_cnt_o    (cycle_cnt),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt),
    .fetch_cnt_o    (fetch_cnt),
    .drop_cnt_o     (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [32:0] exp_q[$];   // {pc, squash}
  int m_cycle, m_stall, m_flush, m_fetch, m_drop;

  function automatic int sat(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  task automatic model_zero();
    exp_q.delete();
    m_cycle = 0; m_stall = 0; m_flush = 0; m_fetch = 0; m_drop = 0;
  endtask

  initial model_zero();

  always @(negedge rst_n) model_zero();

  // Advance the model on each edge from the sampled inputs, then compare
  always @(posedge clk) begin
    bit do_pop, do_push;
    if (rst_n) begin
      if (clear) begin
        model_zero();
      end else begin
        do_pop  = (exp_q.size() != 0) && trace_ready;
`ifdef TRACE_MONITOR_SQUASH_FILTER_EN
        do_push = enable && !stall && !flush;
`else
        do_push = enable && !stall;
`endif
        if (enable)          m_cycle = sat(m_cycle);
        if (enable && stall) m_stall = sat(m_stall);
        if (enable && flush) m_flush = sat(m_flush);
        if (enable && !stall) m_fetch = sat(m_fetch);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({pc, flush});
          else m_drop = sat(m_drop);
        end
      end
    end
    #1;
    compare_all();
  end

  task automatic compare_all();
    logic [32:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 33'd0;
    chk("valid",  64'(trace_valid),  64'(exp_q.size() != 0));
    chk("pc",     64'(trace_pc),     64'(head[32:1]));
    chk("squash", 64'(trace_squash), 64'(head[0]));
    chk("level",  64'(fifo_level),   64'(exp_q.size()));
    chk("cycle",  64'(cycle_cnt),    64'(m_cycle));
    chk("stall",  64'(stall_cnt),    64'(m_stall));
    chk("flush",  64'(flush_cnt),    64'(m_flush));
    chk("fetch",  64'(fetch_cnt),    64'(m_fetch));
    chk("drop",   64'(drop_cnt),     64'(m_drop));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic en, input logic st, input logic fl,
                      input logic rdy, input logic clr, input logic [31:0] p);
    @(negedge clk);
    enable = en; stall = st; flush = fl; trace_ready = rdy; clear = clr; pc = p;
    @(posedge clk);
    #2;
  endtask

  logic [31:0] drain_list [16];

  initial begin
    enable = 0; stall = 0; flush = 0; trace_ready = 0; clear = 0; pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset: run 5 cycles, then assert reset mid-cycle
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0, 32'h40 + 32'(4 * k));
    chk("pre_reset_level", 64'(fifo_level), 64'd5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_cycle", 64'(cycle_cnt), 64'd0);
    chk("rst_fetch", 64'(fetch_cnt), 64'd0);
    chk("rst_pc",    64'(trace_pc),  64'd0);
    enable = 0;
    @(negedge clk) rst_n = 1'b1;

    // Streaming: each PC appears one cycle after it is sampled
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, 1, 0, 32'(4 * k));
      chk("stream_valid", 64'(trace_valid), 64'd1);
      chk("stream_pc",    64'(trace_pc),    64'(4 * k));
    end
    chk("stream_cycle", 64'(cycle_cnt), 64'd10);
    chk("stream_fetch", 64'(fetch_cnt), 64'd10);

    // Stall: no fetches for 3 cycles
    for (int k = 0; k < 3; k++) step(1, 1, 0, 1, 0, 32'h8);
    chk("stall_cnt",   64'(stall_cnt), 64'd3);
    chk("stall_fetch", 64'(fetch_cnt), 64'd10);
    chk("stall_empty", 64'(trace_valid), 64'd0);

    // Overflow: 20 fetches into a 16-deep FIFO
    for (int k = 0; k < 20; k++) step(1, 0, 0, 0, 0, 32'h100 + 32'(4 * k));
    chk("ovf_level", 64'(fifo_level), 64'd16);
    chk("ovf_drop",  64'(drop_cnt),   64'd4);
    chk("ovf_head",  64'(trace_pc),   64'h100);

    // Full push and pop in one cycle
    step(1, 0, 0, 1, 0, 32'h200);
    chk("fpp_level", 64'(fifo_level), 64'd16);
    chk("fpp_drop",  64'(drop_cnt),   64'd4);
    chk("fpp_head",  64'(trace_pc),   64'h104);

    // Drain in order
    for (int i = 0; i < 15; i++) drain_list[i] = 32'h104 + 32'(4 * i);
    drain_list[15] = 32'h200;
    for (int j = 0; j < 16; j++) begin
      chk("drain_pc", 64'(trace_pc), 64'(drain_list[j]));
      step(0, 0, 0, 1, 0, 32'h0);
    end
    chk("drain_level", 64'(fifo_level), 64'd0);
    chk("drain_valid", 64'(trace_valid), 64'd0);

    // Flush fetch at PC 0x20
    step(1, 0, 1, 0, 0, 32'h20);
    chk("flush_cnt",   64'(flush_cnt), 64'd1);
    chk("flush_fetch", 64'(fetch_cnt), 64'd32);
    chk("flush_cycle", 64'(cycle_cnt), 64'd35);
`ifdef TRACE_MONITOR_SQUASH_FILTER_EN
    chk("flush_level", 64'(fifo_level), 64'd0);
`else
    chk("flush_level",  64'(fifo_level),   64'd1);
    chk("flush_pc",     64'(trace_pc),     64'h20);
    chk("flush_squash", 64'(trace_squash), 64'd1);
`endif

    // Clear while full and fetching
    for (int k = 0; k < 17; k++) step(1, 0, 0, 0, 0, 32'h300 + 32'(4 * k));
    chk("pre_clear_level", 64'(fifo_level), 64'd16);
    step(1, 0, 1, 1, 1, 32'h400);
    chk("clr_level", 64'(fifo_level), 64'd0);
    chk("clr_valid", 64'(trace_valid), 64'd0);
    chk("clr_cycle", 64'(cycle_cnt), 64'd0);
    chk("clr_fetch", 64'(fetch_cnt), 64'd0);
    chk("clr_flush", 64'(flush_cnt), 64'd0);
    chk("clr_drop",  64'(drop_cnt),  64'd0);

    // Randomized traffic, long enough between clears to saturate counters
    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 599) == 0),
           $urandom);
    end
    step(0, 0, 0, 0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
